// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: op and state enums,
// opcode/funct3 constants and the NOP used for optional fill (LOADER_ZERO_FILL_EN).
package loader_pkg;

  typedef enum logic [1:0] {
    OP_ADDI = 2'b00,
    OP_BEQ  = 2'b01,
    OP_BNE  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_ZERO_FILL_EN
    S_FILL,
`endif
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [2:0]  F3_ADDI    = 3'b000;
  localparam logic [2:0]  F3_BEQ     = 3'b000;
  localparam logic [2:0]  F3_BNE     = 3'b001;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

endpackage

// File: rtl/program_loader_if.sv
// Instruction-field stream into the loader plus the instruction memory write port.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int INSTR_LEN  = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  op_e                   op;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [12:0]           imm;
  logic                  last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [INSTR_LEN-1:0]  mem_wdata;

  modport master (
    output in_valid, op, rd, rs1, rs2, imm, last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op, rd, rs1, rs2, imm, last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Combinational RV32I encoder for ADDI/BEQ/BNE; flags reserved ops and odd branch offsets.
module instr_encoder
  import loader_pkg::*;
#(
  parameter int INSTR_LEN = 32
) (
  input  op_e                  op,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [12:0]          imm,
  output logic [INSTR_LEN-1:0] word,
  output logic                 illegal
);

  logic [31:0] w;

  always_comb begin
    w       = '0;
    illegal = 1'b0;
    case (op)
      OP_ADDI: w = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
      OP_BEQ, OP_BNE: begin
        w = {imm[12], imm[10:5], rs2, rs1, (op == OP_BEQ) ? F3_BEQ : F3_BNE,
             imm[4:1], imm[11], OPC_BRANCH};
        // Branch targets are halfword aligned, so bit 0 of the offset must be clear.
        illegal = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign word = INSTR_LEN'(w);

endmodule

// File: rtl/program_loader.sv
// Loads encoded instructions into instruction memory while holding the CPU in reset.
// Define LOADER_ZERO_FILL_EN to pad the rest of memory with NOPs after the last instruction.
module program_loader
  import loader_pkg::*;
#(
  parameter int INSTR_LEN  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  state_e                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic                  we_q, we_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [INSTR_LEN-1:0]  wdata_q, wdata_next;
  logic [INSTR_LEN-1:0]  enc_word;
  logic                  enc_illegal;
  logic                  at_end;

  instr_encoder #(.INSTR_LEN(INSTR_LEN)) u_enc (
    .op      (bus.op),
    .rd      (bus.rd),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .imm     (bus.imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign at_end = (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      we_q  <= we_next;
      if (we_next) begin
        addr_q  <= cnt;
        wdata_q <= wdata_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    we_next    = 1'b0;
    wdata_next = enc_word;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_LOAD;
          cnt_next   = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (enc_illegal) begin
            state_next = S_ERR;
          end else begin
            we_next  = 1'b1;
            cnt_next = cnt + ADDR_WIDTH'(1);
            if (bus.last) begin
`ifdef LOADER_ZERO_FILL_EN
              state_next = at_end ? S_DONE : S_FILL;
`else
              state_next = S_DONE;
`endif
            end else if (at_end) begin
              state_next = S_ERR;
            end
          end
        end
      end
`ifdef LOADER_ZERO_FILL_EN
      S_FILL: begin
        we_next    = 1'b1;
        wdata_next = INSTR_LEN'(NOP_WORD);
        cnt_next   = cnt + ADDR_WIDTH'(1);
        if (at_end) state_next = S_DONE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERR);
  assign cpu_hold      = (state != S_DONE);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter INSTR_LEN, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, instruction memory word-address width.
REQ-003 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have: start  input  1  pulse, begins a load session from IDLE.
REQ-006 SHALL have: in_valid  input  1  instruction fields present.
REQ-007 SHALL have: in_ready  output  1  loader accepts fields this cycle.
REQ-008 SHALL have: op  input  2  00 ADDI, 01 BEQ, 10 BNE, 11 reserved.
REQ-009 SHALL have: rd, rs1, rs2  input  5 each  register indices.
REQ-010 SHALL have: imm  input  13  ADDI uses imm[11:0]; branches use a signed byte offset imm[12:0].
REQ-011 SHALL have: last  input  1  marks the final instruction of the session.
REQ-012 SHALL have: mem_we  output  1; mem_addr  output  ADDR_WIDTH; mem_wdata  output  INSTR_LEN  instruction memory write port.
REQ-013 SHALL have: cpu_hold  output  1  holds the CPU in reset while loading.
REQ-014 SHALL have: done  output  1; err  output  1  session status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, FILL, DONE, ERR.
REQ-016 IDLE: start=1 -> LOAD, with the address counter cleared to 0 and done/err cleared; in_valid is ignored.
REQ-017 LOAD: in_ready=1 combinationally; a transfer occurs when in_valid and in_ready are both 1.
REQ-018 On a transfer, SHALL register mem_wdata to the encoded word, mem_addr to the counter and mem_we=1 for exactly one cycle on the next cycle (latency 1); the counter increments.
REQ-019 ADDI encoding SHALL be {imm[11:0], rs1, 3'b000, rd, 7'b0010011}; rs2 is ignored.
REQ-020 BEQ/BNE encoding SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}, with funct3 000 for BEQ and 001 for BNE; rd is ignored.
REQ-021 op=11 or a branch with imm[0]=1 SHALL write nothing and move to ERR.
REQ-022 A transfer with last=1 SHALL go to FILL when REQ-032 is in effect, otherwise to DONE.
REQ-023 A transfer without last at counter = 2^ADDR_WIDTH-1 SHALL be written, then go to ERR (memory full).
REQ-024 A last transfer at the final address SHALL go to DONE directly; no fill occurs.
REQ-025 DONE: done=1 and cpu_hold=0; start=1 begins a new session (-> LOAD).
REQ-026 ERR: err=1 and cpu_hold=1; only start=1 (-> LOAD) or reset leaves ERR.
REQ-027 cpu_hold SHALL be 1 in IDLE, LOAD, FILL and ERR.
REQ-028 start SHALL be ignored in LOAD and FILL.

Reset
REQ-029 rst_n=0 SHALL at once force state IDLE, counter 0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, done=0, err=0 and cpu_hold=1, including during LOAD or FILL.
REQ-030 A write in flight SHALL be dropped on reset; no mem_we pulse follows reset release.

Configuration
REQ-031 Macro LOADER_ZERO_FILL_EN SHALL select NOP fill.
REQ-032 With the macro defined, FILL SHALL write NOP 0x00000013 (addi x0,x0,0) to every address from the counter to 2^ADDR_WIDTH-1, one per cycle with mem_we=1, then go to DONE; in_ready=0 in FILL.
REQ-033 Without the macro, the FILL state and its logic SHALL be absent and last goes straight to DONE.

Structure
REQ-034 loader_pkg SHALL hold the op enum, the state enum, the opcode constants (0010011, 1100011), the funct3 constants and the NOP constant.
REQ-035 The encoding SHALL be in a combinational sub-module instr_encoder (fields in -> word and illegal flag out), instantiated once.

Verification
REQ-036 start; ADDI rd=1 rs1=0 imm=5 last=1 -> one cycle later mem_we=1, addr 0, wdata 0x00500093; then DONE, cpu_hold=0.
REQ-037 BEQ rs1=1 rs2=2 imm=-4, then BNE rs1=2 rs2=0 imm=8 last=1 -> wdata 0xFE208EE3 at addr 0, then 0x00011463 at addr 1.
REQ-038 op=11 at addr 3 -> no mem_we for that transfer, err=1, cpu_hold=1; a later start restarts at addr 0.
REQ-039 ADDR_WIDTH=2, four transfers without last -> four writes, then err=1; with last on the fourth -> done=1 and no fill.
REQ-040 With LOADER_ZERO_FILL_EN and ADDR_WIDTH=3, last at addr 2 -> addrs 3..7 each written 0x00000013 on consecutive cycles, then done=1.
REQ-041 rst_n low mid-LOAD at addr 4 -> outputs reach their reset values with no clock edge; after release, no mem_we pulse occurs and the state is IDLE.
